// File: rtl/irq_dispatch_pkg.sv
// Shared types and defaults for the interrupt dispatcher.
// Optional statistics counters are enabled with IRQ_DISPATCH_STATS_EN.
package irq_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_e;

    localparam int N_CH_DEF     = 4;
    localparam int TIMEOUT_DEF  = 8;
    localparam int COOLDOWN_DEF = 2;
    localparam int MAX_CH       = 32;

    // Wide one-hot; callers truncate to their own channel count.
    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
        onehot = MAX_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_timer.sv
// Loadable down-counter that holds at zero; tc flags the terminal count.
module irq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/irq_dispatch.sv
// Single-outstanding-grant dispatcher with ack/timeout release and cooldown.
// Per-channel completion statistics are added when IRQ_DISPATCH_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a valid encoded request
// GRANT | one-hot grant held until ack or timeout
// COOL  | post-release quiet period, requests ignored
module irq_dispatch
    import irq_dispatch_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int IDX_W    = $clog2(N_CH),
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int COOLDOWN = COOLDOWN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] Y,
    input  logic             valid,
    input  logic             ack,
`ifdef IRQ_DISPATCH_STATS_EN
    input  logic [IDX_W-1:0] stat_sel,
    output logic [7:0]       stat_cnt,
    output logic [7:0]       to_cnt,
`endif
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT - 1);
    localparam logic [3:0] COOL_LOAD = (COOLDOWN > 0) ? 4'(COOLDOWN - 1) : 4'd0;
    localparam bit         HAS_COOL  = (COOLDOWN > 0);

    state_e state;
    logic   capture;
    logic   to_load, to_en, to_tc;
    logic   cool_load, cool_en, cool_tc;
    logic   release_ack, release_to;

    assign capture     = (state == IDLE) && valid && (32'(Y) < N_CH);
    assign release_ack = (state == GRANT) && ack;
    assign release_to  = (state == GRANT) && !ack && to_tc;

    assign to_load   = capture;
    assign to_en     = (state == GRANT) && !ack;
    assign cool_load = release_ack || release_to;
    assign cool_en   = (state == COOL);

    irq_timer #(.W(8)) u_to_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (to_load),
        .load_val (TO_LOAD),
        .en       (to_en),
        .tc       (to_tc)
    );

    irq_timer #(.W(4)) u_cool_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cool_load),
        .load_val (COOL_LOAD),
        .en       (cool_en),
        .tc       (cool_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        grant_id <= Y;
                        grant    <= N_CH'(onehot(32'(Y)));
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // ack takes priority over a coincident terminal count
                    if (release_ack || release_to) begin
                        grant   <= '0;
                        done    <= release_ack;
                        timeout <= release_to;
                        if (HAS_COOL) begin
                            state <= COOL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                COOL: begin
                    if (cool_tc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_DISPATCH_STATS_EN
    logic [7:0] ack_cnt [N_CH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                ack_cnt[i] <= '0;
            end
            to_cnt   <= '0;
            stat_cnt <= '0;
        end else begin
            if (release_ack && (ack_cnt[grant_id] != 8'hFF)) begin
                ack_cnt[grant_id] <= ack_cnt[grant_id] + 8'd1;
            end
            if (release_to && (to_cnt != 8'hFF)) begin
                to_cnt <= to_cnt + 8'd1;
            end
            stat_cnt <= (32'(stat_sel) < N_CH) ? ack_cnt[stat_sel] : 8'd0;
        end
    end
`endif

endmodule
